divider_32bits: RTL and testbench

Sequential 32-bit integer divider for the MIPS datapath. It implements the DIV and DIVU instructions and returns the quotient (LO) and remainder (HI). It uses radix-2 restoring division, one quotient bit per clock, with a start/busy/done handshake, so the pipeline stalls on `busy`. It reuses subtract-and-compare arithmetic, the inverse of the team's carry-lookahead adder datapath.

---
 rtl/divider_32bits.sv | 112 +++++++++++
 tb/tb_divider_32bits.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/divider_32bits.sv
// Sequential radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock; quotient in LO, remainder in HI.
module divider_32bits (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sign,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [32:0] rem;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;

    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [32:0] shifted;
    logic [32:0] trial;

    // Operand magnitudes for signed requests
    always_comb begin
        dvd_mag = (sign && dividend[31]) ? (~dividend + 32'd1) : dividend;
        dvs_mag = (sign && divisor[31]) ? (~divisor + 32'd1) : divisor;
    end

    // One restoring step: shift in the next dividend bit and try a subtract
    always_comb begin
        shifted = {rem[31:0], dvd[31]};
        trial   = shifted - {1'b0, dvs};
    end

    assign busy = (state != IDLE);

    // Control FSM, datapath registers and registered results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == 32'd0) begin
                            quotient  <= 32'hFFFF_FFFF;
                            remainder <= dividend;
                            div_zero  <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            dvd   <= dvd_mag;
                            dvs   <= dvs_mag;
                            neg_q <= sign & (dividend[31] ^ divisor[31]);
                            neg_r <= sign & dividend[31];
                            rem   <= '0;
                            cnt   <= '0;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!trial[32]) begin
                        rem <= trial;
                        dvd <= {dvd[30:0], 1'b1};
                    end else begin
                        rem <= shifted;
                        dvd <= {dvd[30:0], 1'b0};
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= neg_q ? (~dvd + 32'd1) : dvd;
                    remainder <= neg_r ? (~rem[31:0] + 32'd1) : rem[31:0];
                    div_zero  <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32bits.sv
// Directed bench for divider_32bits.
// Hand-computed vectors, latency and handshake checks.
module tb_divider_32bits;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int total;
    int bad;

    divider_32bits dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1. Start edge is edge 0; done expected after
    // edge 'e_edge'; busy expected in 'e_busy' sampled cycles.
    task automatic do_div(input string tag, input logic sg,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic edz, input int e_edge,
                          input int e_busy, input bit inj);
        int lat;
        int bcnt;
        logic [31:0] pq;
        logic [31:0] pr;
        logic changed;
        pq = quotient;
        pr = remainder;
        changed = 1'b0;
        start = 1'b1;
        sign = sg;
        dividend = a;
        divisor = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = 32'h5A5A_5A5A;
        divisor = 32'h0000_0003;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            if (quotient !== pq || remainder !== pr) changed = 1'b1;
            if (inj && lat == 10) begin
                start = 1'b1;
                sign = 1'b0;
                dividend = 32'd999;
                divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, " edge"}, lat, e_edge);
        chk({tag, " busy"}, bcnt, e_busy);
        chk({tag, " hold"}, {31'd0, changed}, 32'd0);
        chk({tag, " q"}, quotient, eq);
        chk({tag, " r"}, remainder, er);
        chk({tag, " dz"}, {31'd0, div_zero}, {31'd0, edz});
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        sign = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst q", quotient, 32'd0);
        chk("rst r", remainder, 32'd0);
        chk("rst dz", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_div("u100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2,
               1'b0, 33, 33, 1'b0);
        @(posedge clk);
        #1;
        chk("done pulse", {31'd0, done}, 32'd0);
        chk("q held", quotient, 32'd14);

        do_div("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD,
               32'hFFFF_FFFF, 1'b0, 33, 33, 1'b0);
        do_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
               32'd1, 1'b0, 33, 33, 1'b0);
        do_div("sm100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,
               32'hFFFF_FFFE, 1'b0, 33, 33, 1'b0);
        do_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h8000_0000, 32'd0, 1'b0, 33, 33, 1'b0);
        do_div("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF,
               32'd0, 1'b0, 33, 33, 1'b0);
        do_div("u_max_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,
               32'd0, 1'b0, 33, 33, 1'b0);
        do_div("u5_9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5,
               1'b0, 33, 33, 1'b0);

        @(posedge clk);
        #1;
        do_div("dz", 1'b0, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234,
               1'b1, 0, 0, 1'b0);
        do_div("after_dz", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0,
               1'b0, 33, 33, 1'b0);

        do_div("ignore", 1'b0, 32'd1000, 32'd9, 32'd111, 32'd1,
               1'b0, 33, 33, 1'b1);
        @(posedge clk);
        #1;
        chk("no 2nd done", {31'd0, done}, 32'd0);
        chk("no 2nd busy", {31'd0, busy}, 32'd0);

        do_div("b2b_a", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7,
               1'b0, 33, 33, 1'b0);
        do_div("b2b_b", 1'b1, 32'hFFFF_FFB3, 32'd10, 32'hFFFF_FFF9,
               32'hFFFF_FFF9, 1'b0, 33, 33, 1'b0);

        start = 1'b1;
        sign = 1'b0;
        dividend = 32'd100;
        divisor = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid rst busy", {31'd0, busy}, 32'd0);
        chk("mid rst done", {31'd0, done}, 32'd0);
        chk("mid rst q", quotient, 32'd0);
        chk("mid rst r", remainder, 32'd0);
        chk("mid rst dz", {31'd0, div_zero}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge clk);
                #1;
                if (done) seen = 1'b1;
            end
            chk("rst no done", {31'd0, seen}, 32'd0);
        end
        do_div("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2,
               1'b0, 33, 33, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
